// File: rtl/bridge_arbiter.sv
// bridge_arbiter: shares the bridge's processor-side port between the CPU data
// port (M0) and a secondary bus master (M1). The CPU wins by default.
// A starvation counter guarantees that M1 is eventually served.
// M1 may hold short locked sequences, capped at MAX_LOCK grants while the CPU waits.
// Grant, bridge drive and read-data return are all combinational in the request cycle.
module bridge_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_LOCK     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdat,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_stall,
  output logic [31:0] m0_rdat,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdat,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic [31:0] m1_rdat,
  output logic [31:0] PRaddr,
  output logic [31:0] PRwdat,
  output logic [3:0]  PRbyteen,
  input  logic [31:0] PRrdat
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE, LOCK1} state_t;

  state_t        state_reg;
  logic [WW-1:0] wait_cnt_reg;
  logic [LW-1:0] lock_cnt_reg;

  logic sel_m0;
  logic sel_m1;
  logic lock_expired;
  logic starved;

  // The lock only yields once it is at its cap and the CPU is actually waiting.
  assign lock_expired = (lock_cnt_reg == LW'(MAX_LOCK)) && m0_req;
  assign starved      = (wait_cnt_reg == WW'(STARVE_LIMIT));

  // Priority grant decision; reset suppresses every grant
  always_comb begin
    sel_m0 = 1'b0;
    sel_m1 = 1'b0;
    if (reset) begin
      sel_m0 = 1'b0;
      sel_m1 = 1'b0;
    end else if ((state_reg == LOCK1) && m1_req && !lock_expired) begin
      sel_m1 = 1'b1;
    end else if (m1_req && starved) begin
      sel_m1 = 1'b1;
    end else if (m0_req) begin
      sel_m0 = 1'b1;
    end else if (m1_req) begin
      sel_m1 = 1'b1;
    end
  end

  assign m0_gnt   = sel_m0;
  assign m1_gnt   = sel_m1;
  assign m0_stall = m0_req && !sel_m0;

  // With no winner, byte enables stay 0 so no device can be written.
  assign PRaddr   = sel_m0 ? m0_addr   : (sel_m1 ? m1_addr   : 32'd0);
  assign PRwdat   = sel_m0 ? m0_wdat   : (sel_m1 ? m1_wdat   : 32'd0);
  assign PRbyteen = sel_m0 ? m0_byteen : (sel_m1 ? m1_byteen : 4'd0);
  assign m0_rdat  = sel_m0 ? PRrdat : 32'd0;
  assign m1_rdat  = sel_m1 ? PRrdat : 32'd0;

  // Lock FSM plus the starvation and lock-length counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      lock_cnt_reg <= '0;
    end else begin
      // Any M1 grant, or M1 going quiet, forgets the accumulated wait.
      if (m1_req && !sel_m1) begin
        if (!starved) begin
          wait_cnt_reg <= wait_cnt_reg + WW'(1);
        end
      end else begin
        wait_cnt_reg <= '0;
      end

      case (state_reg)
        IDLE: begin
          if (sel_m1 && m1_lock) begin
            state_reg    <= LOCK1;
            lock_cnt_reg <= LW'(1);
          end
        end
        LOCK1: begin
          if (!m1_req || !m1_lock || sel_m0) begin
            state_reg    <= IDLE;
            lock_cnt_reg <= '0;
          end else if (sel_m1 && (lock_cnt_reg != LW'(MAX_LOCK))) begin
            lock_cnt_reg <= lock_cnt_reg + LW'(1);
          end
        end
        default: begin
          state_reg    <= IDLE;
          lock_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench for bridge_arbiter.
// Each directed vector states its winner by hand (0 none, 1 M0, 2 M1).
// The expected bus values follow from that winner and the vector's inputs.
// A separate monitor pops and checks one entry per cycle on the falling edge.
module tb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdat = '0, m1_addr = '0, m1_wdat = '0, PRrdat = '0;
  logic [3:0]  m0_byteen = '0, m1_byteen = '0;
  logic        m0_gnt, m0_stall, m1_gnt;
  logic [31:0] m0_rdat, m1_rdat, PRaddr, PRwdat;
  logic [3:0]  PRbyteen;

  // staged data inputs, applied to the DUT by the next step call
  logic [31:0] a0_v = '0, w0_v = '0, a1_v = '0, w1_v = '0, rd_v = '0;
  logic [3:0]  b0_v = '0, b1_v = '0;

  typedef struct {
    int          id;
    logic        m0g, m1g, st;
    logic [31:0] pa, pw, r0, r1;
    logic [3:0]  pb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   vec_n = 0;

  bridge_arbiter #(.STARVE_LIMIT(8), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdat(m0_wdat), .m0_byteen(m0_byteen),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rdat(m0_rdat),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdat(m1_wdat),
    .m1_byteen(m1_byteen), .m1_gnt(m1_gnt), .m1_rdat(m1_rdat),
    .PRaddr(PRaddr), .PRwdat(PRwdat), .PRbyteen(PRbyteen), .PRrdat(PRrdat)
  );

  always #5 clk = ~clk;

  // one vector per clock cycle: drive just after the rising edge, queue the expectation
  task automatic step(input logic rst_i, input logic r0, input logic r1,
                      input logic lk, input int win);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_i;
    m0_req = r0; m0_addr = a0_v; m0_wdat = w0_v; m0_byteen = b0_v;
    m1_req = r1; m1_lock = lk; m1_addr = a1_v; m1_wdat = w1_v; m1_byteen = b1_v;
    PRrdat = rd_v;
    e.id  = vec_n;
    e.m0g = (win == 1);
    e.m1g = (win == 2);
    e.st  = r0 && (win != 1);
    e.pa  = (win == 1) ? a0_v : ((win == 2) ? a1_v : 32'd0);
    e.pw  = (win == 1) ? w0_v : ((win == 2) ? w1_v : 32'd0);
    e.pb  = (win == 1) ? b0_v : ((win == 2) ? b1_v : 4'd0);
    e.r0  = (win == 1) ? rd_v : 32'd0;
    e.r1  = (win == 2) ? rd_v : 32'd0;
    q.push_back(e);
    vec_n++;
  endtask

  // monitor: compare the outputs present in each cycle with the queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({m0_gnt, m1_gnt, m0_stall} !== {e.m0g, e.m1g, e.st}) begin
        bad++;
        $display("FAIL gnt vec=%0d got m0_gnt/m1_gnt/stall=%b%b%b want %b%b%b",
                 e.id, m0_gnt, m1_gnt, m0_stall, e.m0g, e.m1g, e.st);
      end else begin
        $display("vec=%0d gnt m0=%b m1=%b stall=%b ok", e.id, m0_gnt, m1_gnt, m0_stall);
      end
      total++;
      if ({PRaddr, PRwdat, PRbyteen, m0_rdat, m1_rdat} !== {e.pa, e.pw, e.pb, e.r0, e.r1}) begin
        bad++;
        $display("FAIL bus vec=%0d got addr=%h wdat=%h be=%h r0=%h r1=%h want addr=%h wdat=%h be=%h r0=%h r1=%h",
                 e.id, PRaddr, PRwdat, PRbyteen, m0_rdat, m1_rdat, e.pa, e.pw, e.pb, e.r0, e.r1);
      end
    end
  end

  initial begin
    // reset held: no grants, bus quiet
    step(1, 0, 0, 0, 0);
    // no requests
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // M0-only read
    a0_v = 32'h0000_1000; w0_v = 32'h0; b0_v = 4'h0; rd_v = 32'hDEAD_BEEF;
    step(0, 1, 0, 0, 1);

    // both held, no lock: M1 forced in cycles 9 and 18
    a0_v = 32'h0000_2000; w0_v = 32'h1234_5678; b0_v = 4'h0;
    a1_v = 32'h0000_3000; w1_v = 32'h1111_2222; b1_v = 4'h3; rd_v = 32'h0BAD_F00D;
    for (int i = 1; i <= 18; i++) step(0, 1, 1, 0, ((i == 9) || (i == 18)) ? 2 : 1);
    step(0, 0, 0, 0, 0);

    // lock entered alone, CPU arrives: 4 M1 grants then M0, then back in IDLE
    a1_v = 32'h0000_4000; w1_v = 32'h0; b1_v = 4'h0; rd_v = 32'hCAFE_0001;
    step(0, 0, 1, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 2);
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    // uncontended lock runs past MAX_LOCK; CPU then wins at once
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 2);
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    // M1 write to 0x7F00 while M0 reads: bus carries M1 only in its grant cycle
    a0_v = 32'h0000_0100; w0_v = 32'h0; b0_v = 4'h0;
    a1_v = 32'h0000_7F00; w1_v = 32'hA5A5_5A5A; b1_v = 4'hF; rd_v = 32'h0;
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 2);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // reset mid-lock: quiet during reset, then wait counting restarts from 0
    a1_v = 32'h0000_5000; w1_v = 32'h0; b1_v = 4'h0; rd_v = 32'h5555_AAAA;
    step(0, 0, 1, 1, 2);
    step(0, 1, 1, 1, 2);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
